// File: rtl/discrete_pkg.sv
// Shared constants, types and helpers for the discrete-audio effect generators.
//   SIG_WIDTH / SIG_FRAC : default signed sample width and fraction bits
//   volt_to_sig()        : millivolt level -> fixed-point signal value
//   env_state_t          : envelope state encoding
//   saturate()           : clamp a 32-bit signed value into a w-bit signed range
package discrete_pkg;

  localparam int unsigned SIG_WIDTH      = 16;
  localparam int unsigned SIG_FRAC       = SIG_WIDTH - 2;
  localparam int          SIG_FULL_SCALE = 1 << SIG_FRAC;

  // Scale a millivolt level so that full_mv maps onto full scale.
  function automatic int volt_to_sig(input int mv, input int full_mv);
    return (mv * SIG_FULL_SCALE) / full_mv;
  endfunction

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_HOLD,
    ENV_RELEASE
  } env_state_t;

  // Clamp x into [-(2^(w-1)), 2^(w-1)-1].
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned       w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/shift_one_pole_filter.sv
// One-pole shift filter: s += (x - s) >>> SHIFT on each enabled cycle.
//   Low-pass mode : y = s (registered state)
//   High-pass mode: y = x - s, computed against the state before its update
//   Ports: clk, I_RSTn (async active-low), en (advance strobe), x in, y out
module shift_one_pole_filter #(
  parameter int unsigned             WIDTH     = 16,
  parameter int unsigned             SHIFT     = 8,
  parameter bit                      HIGH_PASS = 1'b1,
  parameter logic signed [WIDTH-1:0] INIT      = '0
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  localparam int unsigned DW = WIDTH + 1;

  logic signed [WIDTH-1:0] s_q;
  logic signed [DW-1:0]    diff;
  logic signed [DW-1:0]    step;
  logic signed [WIDTH-1:0] s_d;

  // One guard bit keeps x - s from wrapping before the shift.
  always_comb begin
    diff = DW'(x) - DW'(s_q);
    step = diff >>> SHIFT;
    s_d  = WIDTH'(DW'(s_q) + step);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)  s_q <= INIT;
    else if (en)  s_q <= s_d;
  end

  if (HIGH_PASS) begin : g_hp
    logic signed [WIDTH-1:0] h_q;
    always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) h_q <= '0;
      else if (en) h_q <= WIDTH'(diff);
    end
    assign y = h_q;
  end else begin : g_lp
    assign y = s_q;
  end

endmodule

// File: rtl/triggered_vco_voice.sv
// Triggered sound-effect voice: envelope FSM gated by an LFO-switched
// two-pitch square VCO, DC-blocking high-pass and asymmetric output gain.
//   clk, I_RSTn  : clock, async active-low reset
//   audio_clk_en : sample strobe; all state advances only on it
//   trig         : level trigger (ONE_SHOT=0) or edge trigger (ONE_SHOT=1)
//   busy         : envelope not idle (decoded from the state register)
//   out          : registered signed audio sample
module triggered_vco_voice
  import discrete_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter bit          ONE_SHOT        = 1'b0,
  parameter int unsigned ATTACK_STEP     = 512,
  parameter int unsigned RELEASE_STEP    = 64,
  parameter int unsigned HOLD_SAMPLES    = 4800,
  parameter int unsigned LFO_HALF_PERIOD = 2400,
  parameter int unsigned PHASE_W         = 24,
  parameter int unsigned VCO_INC_LO      = 201327,
  parameter int unsigned VCO_INC_HI      = 285213,
  parameter int unsigned INC_LPF_SHIFT   = 6,
  parameter int unsigned HPF_SHIFT       = 8,
  parameter int unsigned FLOOR           = 16
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    audio_clk_en,
  input  logic                    trig,
  output logic                    busy,
  output logic signed [WIDTH-1:0] out
);

  localparam int unsigned FRAC   = WIDTH - 2;
  localparam int unsigned ENV_W  = FRAC + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned LFO_W  = $clog2(LFO_HALF_PERIOD + 1);
  localparam int unsigned OW     = WIDTH + 2;
  localparam logic [ENV_W-1:0] ENV_FS = {1'b1, {FRAC{1'b0}}};

  env_state_t          state_q, state_d;
  logic [ENV_W-1:0]    env_q, env_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                trig_q;
  logic                rise;
  logic                start;
  logic                lfo_clr;
  logic [ENV_W:0]      env_sum;
  logic [ENV_W-1:0]    env_up;
  logic [ENV_W-1:0]    env_dn;

  logic [LFO_W-1:0]    lfo_cnt_q;
  logic                lfo_q;
  logic signed [PHASE_W-1:0] inc_target;
  logic signed [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0]  phase_q;
  logic                vco;

  logic [ENV_W-1:0]    env_gate;
  logic signed [WIDTH-1:0] g;
  logic signed [WIDTH-1:0] h;
  logic signed [OW-1:0]    hx;
  logic signed [OW-1:0]    shaped;
  logic signed [WIDTH-1:0] out_d;

  assign rise  = trig & ~trig_q;
  assign start = ONE_SHOT ? rise : trig;
  assign busy  = (state_q != ENV_IDLE);

  // Envelope next-state and level.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    hold_d  = hold_q;
    lfo_clr = 1'b0;
    env_sum = {1'b0, env_q} + (ENV_W + 1)'(ATTACK_STEP);
    env_up  = (env_sum > {1'b0, ENV_FS}) ? ENV_FS : env_sum[ENV_W-1:0];
    env_dn  = (env_q > ENV_W'(RELEASE_STEP)) ? env_q - ENV_W'(RELEASE_STEP) : '0;
    case (state_q)
      ENV_IDLE: begin
        env_d = '0;
        if (start) begin
          state_d = ENV_ATTACK;
          lfo_clr = 1'b1;
        end
      end
      ENV_ATTACK: begin
        if (!ONE_SHOT && !trig) begin
          state_d = ENV_RELEASE;
        end else begin
          env_d = env_up;
          if (env_up == ENV_FS) begin
            state_d = ONE_SHOT ? ENV_HOLD : ENV_SUSTAIN;
            hold_d  = HOLD_W'(HOLD_SAMPLES - 1);
          end
        end
      end
      ENV_SUSTAIN: begin
        if (!trig) state_d = ENV_RELEASE;
      end
      ENV_HOLD: begin
        if (rise)             state_d = ENV_ATTACK;
        else if (hold_q == '0) state_d = ENV_RELEASE;
        else                  hold_d  = hold_q - HOLD_W'(1);
      end
      ENV_RELEASE: begin
        if (start) begin
          state_d = ENV_ATTACK;
        end else begin
          env_d = env_dn;
          if (env_dn == '0) state_d = ENV_IDLE;
        end
      end
      default: begin
        state_d = ENV_IDLE;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= ENV_IDLE;
      env_q   <= '0;
      hold_q  <= '0;
      trig_q  <= 1'b0;
    end else if (audio_clk_en) begin
      state_q <= state_d;
      env_q   <= env_d;
      hold_q  <= hold_d;
      trig_q  <= trig;
    end
  end

  // Square LFO, restarted at the start of every note.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      lfo_cnt_q <= '0;
      lfo_q     <= 1'b0;
    end else if (audio_clk_en) begin
      if (lfo_clr) begin
        lfo_cnt_q <= '0;
        lfo_q     <= 1'b0;
      end else if (lfo_cnt_q == LFO_W'(LFO_HALF_PERIOD - 1)) begin
        lfo_cnt_q <= '0;
        lfo_q     <= ~lfo_q;
      end else begin
        lfo_cnt_q <= lfo_cnt_q + LFO_W'(1);
      end
    end
  end

  assign inc_target = lfo_q ? PHASE_W'(VCO_INC_HI) : PHASE_W'(VCO_INC_LO);

  // Glide between the two pitches.
  shift_one_pole_filter #(
    .WIDTH     (PHASE_W),
    .SHIFT     (INC_LPF_SHIFT),
    .HIGH_PASS (1'b0),
    .INIT      (PHASE_W'(VCO_INC_LO))
  ) u_inc_lpf (
    .clk    (clk),
    .I_RSTn (I_RSTn),
    .en     (audio_clk_en),
    .x      (inc_target),
    .y      (inc)
  );

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)           phase_q <= '0;
    else if (audio_clk_en) phase_q <= phase_q + unsigned'(inc);
  end

  assign vco = phase_q[PHASE_W-1];

  // VCO high pulls the envelope down to the floor level.
  always_comb begin
    env_gate = (vco && (env_q > ENV_W'(FLOOR))) ? ENV_W'(FLOOR) : env_q;
    g        = signed'({1'b0, env_gate});
  end

  shift_one_pole_filter #(
    .WIDTH     (WIDTH),
    .SHIFT     (HPF_SHIFT),
    .HIGH_PASS (1'b1),
    .INIT      ('0)
  ) u_hpf (
    .clk    (clk),
    .I_RSTn (I_RSTn),
    .en     (audio_clk_en),
    .x      (g),
    .y      (h)
  );

  // Diode-style asymmetric gain: x1.5 positive, x0.75 negative.
  always_comb begin
    hx     = OW'(h);
    shaped = (h > 0) ? hx + (hx >>> 1) : (hx >>> 1) + (hx >>> 2);
    out_d  = WIDTH'(saturate(32'(shaped), WIDTH));
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)           out <= '0;
    else if (audio_clk_en) out <= out_d;
  end

endmodule

// File: tb/tb_triggered_vco_voice.sv
// Directed bench for triggered_vco_voice: a level-mode instance with a fast
// LFO and no glide, and a one-shot instance with a short hold.
module tb_triggered_vco_voice;
  import discrete_pkg::*;

  localparam int INC_LO = 201327;
  localparam int INC_HI = 285213;

  logic clk = 1'b0;
  logic I_RSTn = 1'b0;
  logic audio_clk_en = 1'b0;
  logic trig_a = 1'b0;
  logic trig_b = 1'b0;
  logic busy_a, busy_b;
  logic signed [15:0] out_a, out_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  triggered_vco_voice #(
    .ONE_SHOT        (1'b0),
    .LFO_HALF_PERIOD (4),
    .INC_LPF_SHIFT   (0)
  ) u_a (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .trig         (trig_a),
    .busy         (busy_a),
    .out          (out_a)
  );

  triggered_vco_voice #(
    .ONE_SHOT     (1'b1),
    .HOLD_SAMPLES (10)
  ) u_b (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .trig         (trig_b),
    .busy         (busy_b),
    .out          (out_b)
  );

  task automatic strobe();
    @(negedge clk); audio_clk_en = 1'b1;
    @(negedge clk); audio_clk_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    I_RSTn = 1'b1;
    @(negedge clk);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a got %0b want 0", busy_a); end
    tests++; if (out_a !== 16'sd0) begin fails++; $display("FAIL reset_out_a got %0d want 0", out_a); end
    tests++; if (u_a.inc !== 24'(INC_LO)) begin fails++; $display("FAIL reset_inc got %0d want %0d", u_a.inc, INC_LO); end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy_b got %0b want 0", busy_b); end
    tests++; if (out_b !== 16'sd0) begin fails++; $display("FAIL reset_out_b got %0d want 0", out_b); end
  endtask

  task automatic test_no_strobe();
    trig_a = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL no_strobe_busy got %0b want 0", busy_a); end
    tests++; if (u_a.env_q !== 15'd0) begin fails++; $display("FAIL no_strobe_env got %0d want 0", u_a.env_q); end
  endtask

  task automatic test_level();
    int hb, exp_out, exp_phase, inc_j, nrel, omin, omax;
    bit neg_seen;
    exp_phase = 0; neg_seen = 1'b0; omin = 0; omax = 0;
    trig_a = 1'b1;
    for (int k = 0; k < 100; k++) begin
      inc_j = (k < 6) ? INC_LO : ((((k - 6) / 4) % 2) == 0 ? INC_HI : INC_LO);
      exp_phase = (exp_phase + inc_j) % (1 << 24);
      hb = int'(u_a.h);
      if (hb <= 0 && hb != 0) neg_seen = 1'b1;
      exp_out = (hb > 0) ? hb + (hb >>> 1) : (hb >>> 1) + (hb >>> 2);
      strobe();
      tests++; if (int'(out_a) !== exp_out) begin fails++; $display("FAIL shape_k%0d got %0d want %0d", k, out_a, exp_out); end
      if (int'(out_a) < omin) omin = int'(out_a);
      if (int'(out_a) > omax) omax = int'(out_a);
      if (k == 0) begin
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL level_busy_rise got %0b want 1", busy_a); end
        tests++; if (u_a.env_q !== 15'd0) begin fails++; $display("FAIL level_env0 got %0d want 0", u_a.env_q); end
      end
      if (k == 3) begin tests++; if (out_a !== 16'sd768) begin fails++; $display("FAIL out_k3 got %0d want 768", out_a); end end
      if (k == 4) begin tests++; if (out_a !== 16'sd1533) begin fails++; $display("FAIL out_k4 got %0d want 1533", out_a); end end
      if (k == 5) begin tests++; if (out_a !== 16'sd2296) begin fails++; $display("FAIL out_k5 got %0d want 2296", out_a); end end
      if (k == 4 || k == 9) begin
        tests++; if (u_a.inc !== 24'(INC_LO)) begin fails++; $display("FAIL inc_k%0d got %0d want %0d", k, u_a.inc, INC_LO); end
      end
      if (k == 5 || k == 8) begin
        tests++; if (u_a.inc !== 24'(INC_HI)) begin fails++; $display("FAIL inc_k%0d got %0d want %0d", k, u_a.inc, INC_HI); end
      end
      if (k == 31) begin
        tests++; if (u_a.env_q !== 15'd15872 || u_a.state_q !== ENV_ATTACK) begin
          fails++; $display("FAIL attack_k31 got env %0d state %0d want 15872 ATTACK", u_a.env_q, u_a.state_q); end
      end
      if (k == 32 || k == 99) begin
        tests++; if (u_a.env_q !== 15'd16384 || u_a.state_q !== ENV_SUSTAIN) begin
          fails++; $display("FAIL sustain_k%0d got env %0d state %0d want 16384 SUSTAIN", k, u_a.env_q, u_a.state_q); end
      end
    end
    tests++; if (int'(u_a.phase_q) !== exp_phase) begin fails++; $display("FAIL phase_wrap got %0d want %0d", u_a.phase_q, exp_phase); end

    trig_a = 1'b0;
    nrel = 0;
    for (int k = 0; k < 400 && busy_a; k++) begin
      hb = int'(u_a.h);
      if (hb < 0) neg_seen = 1'b1;
      exp_out = (hb > 0) ? hb + (hb >>> 1) : (hb >>> 1) + (hb >>> 2);
      strobe();
      tests++; if (int'(out_a) !== exp_out) begin fails++; $display("FAIL shape_rel%0d got %0d want %0d", k, out_a, exp_out); end
      if (int'(out_a) < omin) omin = int'(out_a);
      if (int'(out_a) > omax) omax = int'(out_a);
      if (u_a.state_q == ENV_RELEASE) nrel++;
    end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL release_timeout busy got %0b want 0", busy_a); end
    tests++; if (nrel !== 256) begin fails++; $display("FAIL release_len got %0d want 256", nrel); end
    tests++; if (u_a.env_q !== 15'd0) begin fails++; $display("FAIL release_env got %0d want 0", u_a.env_q); end
    tests++; if (neg_seen !== 1'b1) begin fails++; $display("FAIL neg_excursion got %0b want 1", neg_seen); end
    tests++; if (omin < -12288 || omax > 24576) begin fails++; $display("FAIL out_range got [%0d,%0d] want within [-12288,24576]", omin, omax); end
  endtask

  task automatic test_one_shot();
    int natt, nhold, nrel;
    natt = 0; nhold = 0; nrel = 0;
    trig_b = 1'b1;
    strobe();
    trig_b = 1'b0;
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL oneshot_busy got %0b want 1", busy_b); end
    if (u_b.state_q == ENV_ATTACK) natt++;
    for (int k = 0; k < 600 && busy_b; k++) begin
      strobe();
      if (u_b.state_q == ENV_ATTACK)  natt++;
      if (u_b.state_q == ENV_HOLD)    nhold++;
      if (u_b.state_q == ENV_RELEASE) nrel++;
    end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL oneshot_timeout busy got %0b want 0", busy_b); end
    tests++; if (natt !== 32) begin fails++; $display("FAIL oneshot_attack got %0d want 32", natt); end
    tests++; if (nhold !== 10) begin fails++; $display("FAIL oneshot_hold got %0d want 10", nhold); end
    tests++; if (nrel !== 256) begin fails++; $display("FAIL oneshot_release got %0d want 256", nrel); end
  endtask

  task automatic test_retrigger();
    bit found;
    found = 1'b0;
    trig_b = 1'b1;
    strobe();
    trig_b = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      strobe();
      if (u_b.state_q == ENV_RELEASE && u_b.env_q == 15'd8000) found = 1'b1;
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL retrig_reach8000 got %0b want 1", found); end
    trig_b = 1'b1;
    strobe();
    trig_b = 1'b0;
    tests++; if (u_b.state_q !== ENV_ATTACK || u_b.env_q !== 15'd8000) begin
      fails++; $display("FAIL retrig_entry got env %0d state %0d want 8000 ATTACK", u_b.env_q, u_b.state_q); end
    repeat (16) strobe();
    tests++; if (u_b.state_q !== ENV_ATTACK || u_b.env_q !== 15'd16192) begin
      fails++; $display("FAIL retrig_16 got env %0d state %0d want 16192 ATTACK", u_b.env_q, u_b.state_q); end
    strobe();
    tests++; if (u_b.state_q !== ENV_HOLD || u_b.env_q !== 15'd16384) begin
      fails++; $display("FAIL retrig_17 got env %0d state %0d want 16384 HOLD", u_b.env_q, u_b.state_q); end
    for (int k = 0; k < 600 && busy_b; k++) strobe();
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL retrig_drain busy got %0b want 0", busy_b); end
  endtask

  task automatic test_reset_mid_attack();
    trig_a = 1'b1;
    repeat (5) strobe();
    tests++; if (u_a.env_q !== 15'd2048) begin fails++; $display("FAIL mid_attack_env got %0d want 2048", u_a.env_q); end
    trig_b = 1'b1;
    I_RSTn = 1'b0;
    #1;
    tests++; if (u_a.env_q !== 15'd0) begin fails++; $display("FAIL rst_env got %0d want 0", u_a.env_q); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b want 0", busy_a); end
    tests++; if (out_a !== 16'sd0) begin fails++; $display("FAIL rst_out got %0d want 0", out_a); end
    tests++; if (u_a.inc !== 24'(INC_LO)) begin fails++; $display("FAIL rst_inc got %0d want %0d", u_a.inc, INC_LO); end
    tests++; if (u_a.phase_q !== 24'd0) begin fails++; $display("FAIL rst_phase got %0d want 0", u_a.phase_q); end
    repeat (2) @(negedge clk);
    I_RSTn = 1'b1;
    strobe();
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL post_rst_level got %0b want 1", busy_a); end
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL post_rst_edge got %0b want 1", busy_b); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_strobe();
    test_level();
    test_one_shot();
    test_retrigger();
    test_reset_mid_attack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
